ifu_fetchgroup_queue: RTL and testbench
=======================================

# ifu_fetchgroup_queue

Fetch-group producer at the IFU/decode boundary. Accepts one 128-bit aligned fetch line per cycle from the instruction fetch stage, builds the fetch group (16-byte-aligned group PC, four instruction slots, contiguous valid-word mask), buffers groups in a small FIFO and drives them to decode as the master of `pip_ifu_interface`. Decode consumes each group over one or more cycles and asserts ready only when the whole group is consumed; this block holds the head group stable until then.

## Interface
- `DEPTH`, 4, number of buffered fetch groups; power of two, minimum 2.
- `clk_i`  in  1  clock.
- `arst_i`  in  1  reset, asynchronous, active-high.
- `fetch_valid_i`  in  1  fetch line valid.
- `fetch_ready_o`  out  1  queue can accept a line (not full).
- `fetch_pc_i`  in  XLEN  PC of the first useful instruction; bits [1:0] are 0.
- `fetch_line_i`  in  128  four instructions; slot k at bits [32k+31:32k].
- `fetch_taken_i`  in  1  predictor marks a taken branch inside this line.
- `fetch_taken_slot_i`  in  2  slot index of the taken branch.
- `fetch_output`  `pip_ifu_interface.master`  group to decode: `valid` out, `ready` in, `instr[127:0]` out, `grouppc[XLEN-1:0]` out, `validword[3:0]` out.
- `pip_flush_sif`  `pip_flush_interface.slave`  `flush` in, 1, pipeline flush.
- `count_o`  out  $clog2(DEPTH)+1  groups currently held.

## Operation
- Group build on push: start = `fetch_pc_i[3:2]`; end = `fetch_taken_i ? fetch_taken_slot_i : 3`; if end < start, end = start. `validword` bit k = 1 for start ≤ k ≤ end, else 0. `grouppc` = `{fetch_pc_i[XLEN-1:4], 4'h0}`. `instr` = `fetch_line_i` unmodified.
- Resulting masks are always one of 0001,0011,0111,1111,0010,0110,1110,0100,1100,1000; never 0000.
- Storage: DEPTH entries of {instr, grouppc, validword}; read pointer and write pointer each $clog2(DEPTH)+1 bits (extra wrap bit). Empty: pointers equal. Full: index bits equal, wrap bits differ.
- Push: `fetch_valid_i & fetch_ready_o & ~flush`. Pop: `fetch_output.valid & fetch_output.ready & ~flush`.
- `fetch_ready_o` = not full; no same-cycle pop-through (a full queue refuses a push even when popping that cycle).
- `fetch_output.valid` = not empty. `instr`, `grouppc`, `validword` come from the head entry; when empty `validword` = 0000, other fields don't-care.
- Simultaneous push and pop when neither empty nor full: both take effect, count unchanged.
- Push into empty queue: group visible on output the following cycle (no bypass).
- Flush: both pointers and count cleared at the next edge; any push or pop in the flush cycle is discarded. Output data is ignored by decode during flush.
- Pointers wrap naturally at 2·DEPTH; count = write pointer − read pointer, modulo 2·DEPTH.

## Timing
- Reset (async, arst_i high): pointers 0, count_o 0, `fetch_output.valid` 0, `validword` 0000, `fetch_ready_o` 1. Storage array not reset.
- Push-to-output latency 1 cycle; pop takes effect at the edge where valid & ready are high.
- Head entry fields held stable while valid & ~ready; decode relies on this across its multi-cycle drain.
- `fetch_output.valid` depends only on registered state; no combinational path from `fetch_output.ready` to `fetch_ready_o` or to `fetch_output.valid`.
- Reset asserted mid-operation: queue empties immediately, no partial group output after release.

## Test plan
- Reset then push pc=0x1008, no taken → next cycle valid=1, grouppc=0x1000, validword=0100... corrected: start=2,end=3 → validword=1100, count_o=1.
- Push pc=0x2004, taken slot 2 → validword=0110; push pc=0x200C, taken slot 1 → validword=1000 (end clamped to start).
- Push DEPTH groups with ready=0 → fetch_ready_o=0 after 4th push, count_o=4; fifth push ignored; then ready=1 for 4 cycles → groups leave in push order, then valid=0.
- Hold ready=0 for 3 cycles with head valid → instr/grouppc/validword unchanged every cycle; concurrent push/pop at count 2 → count stays 2.
- 3 groups queued, assert flush with push and pop active → next cycle count_o=0, valid=0, validword=0000, fetch_ready_o=1.
- Stream 10 groups with random ready → output order and contents match push order across pointer wrap; arst_i mid-stream → count_o=0, valid=0 asynchronously.

Source files
------------

// File: rtl/ifu_fetchgroup_queue_if.sv
// Pipeline interfaces used at the IFU/decode boundary.
//   pip_ifu_interface   : fetch group handed from IFU to decode
//   pip_flush_interface : pipeline-wide flush strobe

interface pip_ifu_interface #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [127:0]    instr;
  logic [XLEN-1:0] grouppc;
  logic [3:0]      validword;

  modport master (output valid, output instr, output grouppc, output validword, input ready);
  modport slave  (input valid, input instr, input grouppc, input validword, output ready);
endinterface

interface pip_flush_interface;
  logic flush;

  modport master (output flush);
  modport slave  (input flush);
endinterface

// File: rtl/ifu_fetchgroup_queue.sv
// Fetch-group queue between the IFU and decode.
// Builds a 16-byte-aligned fetch group (group PC, four slots, contiguous
// valid-word mask) from each accepted fetch line and buffers DEPTH groups.
// The head group is held stable on the output until decode accepts it.

module ifu_fetchgroup_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic [127:0]             fetch_line_i,
  input  logic                     fetch_taken_i,
  input  logic [1:0]               fetch_taken_slot_i,
  pip_ifu_interface.master         fetch_output,
  pip_flush_interface.slave        pip_flush_sif,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;

  logic [127:0]    r_instr_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [3:0]      r_vw_mem    [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_flush;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_start;
  logic [1:0]      w_end_raw;
  logic [1:0]      w_end;
  logic [3:0]      w_validword;
  logic [XLEN-1:0] w_grouppc;
  logic [AW-1:0]   w_head_idx;
  logic            w_unused_pc_lsbs;

  // PC bits [1:0] are always zero for aligned instructions.
  assign w_unused_pc_lsbs = ^fetch_pc_i[1:0];

  assign w_flush = pip_flush_sif.flush;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // A full queue refuses a push even if the head leaves in the same cycle.
  assign w_push  = fetch_valid_i & ~w_full & ~w_flush;
  assign w_pop   = ~w_empty & fetch_output.ready & ~w_flush;

  // Group range: first useful slot up to the taken branch (or slot 3),
  // clamped so that the mask never becomes empty.
  assign w_start   = fetch_pc_i[3:2];
  assign w_end_raw = fetch_taken_i ? fetch_taken_slot_i : 2'd3;
  assign w_end     = (w_end_raw < w_start) ? w_start : w_end_raw;
  assign w_grouppc = {fetch_pc_i[XLEN-1:4], 4'h0};

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign w_validword[gi] = (2'(gi) >= w_start) && (2'(gi) <= w_end);
  end

  // Group storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr_mem[r_wptr[AW-1:0]] <= fetch_line_i;
      r_pc_mem[r_wptr[AW-1:0]]    <= w_grouppc;
      r_vw_mem[r_wptr[AW-1:0]]    <= w_validword;
    end
  end

  // Pointer update; flush discards any push or pop of the same cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  assign w_head_idx = r_rptr[AW-1:0];

  // Outputs depend only on registered pointers and storage.
  assign fetch_ready_o          = ~w_full;
  assign fetch_output.valid     = ~w_empty;
  assign fetch_output.instr     = r_instr_mem[w_head_idx];
  assign fetch_output.grouppc   = r_pc_mem[w_head_idx];
  assign fetch_output.validword = w_empty ? 4'b0000 : r_vw_mem[w_head_idx];
  assign count_o                = r_wptr - r_rptr;

endmodule

// File: tb/tb_ifu_fetchgroup_queue.sv
// Self-checking bench for ifu_fetchgroup_queue with a group scoreboard.

module tb_ifu_fetchgroup_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [127:0]    instr;
    logic [XLEN-1:0] pc;
    logic [3:0]      vw;
  } grp_t;

  logic            clk_i = 1'b0;
  logic            arst_i;
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [XLEN-1:0] fetch_pc_i;
  logic [127:0]    fetch_line_i;
  logic            fetch_taken_i;
  logic [1:0]      fetch_taken_slot_i;
  logic [$clog2(DEPTH):0] count_o;

  pip_ifu_interface #(.XLEN(XLEN)) fo_if ();
  pip_flush_interface              fl_if ();

  ifu_fetchgroup_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i              (clk_i),
    .arst_i             (arst_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_line_i       (fetch_line_i),
    .fetch_taken_i      (fetch_taken_i),
    .fetch_taken_slot_i (fetch_taken_slot_i),
    .fetch_output       (fo_if),
    .pip_flush_sif      (fl_if),
    .count_o            (count_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  grp_t sb_q[$];
  int   pops = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference group model.
  function automatic grp_t model(input logic [XLEN-1:0] pc, input logic [127:0] line,
                                 input logic tk, input logic [1:0] slot);
    grp_t g;
    int s, e;
    s = int'(pc[3:2]);
    e = tk ? int'(slot) : 3;
    if (e < s) e = s;
    g.instr = line;
    g.pc    = {pc[XLEN-1:4], 4'h0};
    g.vw    = 4'b0000;
    for (int k = 0; k < 4; k++) if (k >= s && k <= e) g.vw[k] = 1'b1;
    return g;
  endfunction

  // Scoreboard: compare occupancy each cycle, pop on handshake, push on accept.
  always @(negedge clk_i) begin
    if (!arst_i) begin
      check("count", 128'(count_o), 128'(sb_q.size()));
      check("valid", 128'(fo_if.valid), 128'(sb_q.size() != 0));
      if (fo_if.valid && fo_if.ready && !fl_if.flush) begin
        if (sb_q.size() == 0) begin
          check("pop_unexpected", 128'(1), 128'(0));
        end else begin
          grp_t e;
          e = sb_q.pop_front();
          pops++;
          check("pop_instr", fo_if.instr, e.instr);
          check("pop_grouppc", 128'(fo_if.grouppc), 128'(e.pc));
          check("pop_validword", 128'(fo_if.validword), 128'(e.vw));
          $display("pop  pc=%h vw=%b", fo_if.grouppc, fo_if.validword);
        end
      end
      if (fetch_valid_i && fetch_ready_o && !fl_if.flush) begin
        sb_q.push_back(model(fetch_pc_i, fetch_line_i, fetch_taken_i, fetch_taken_slot_i));
        $display("push pc=%h taken=%0d slot=%0d", fetch_pc_i, fetch_taken_i, fetch_taken_slot_i);
      end
      if (fl_if.flush) begin
        sb_q.delete();
        $display("flush");
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] pc, input logic [127:0] line,
                       input logic tk, input logic [1:0] slot);
    fetch_valid_i      = 1'b1;
    fetch_pc_i         = pc;
    fetch_line_i       = line;
    fetch_taken_i      = tk;
    fetch_taken_slot_i = slot;
    step();
    fetch_valid_i = 1'b0;
  endtask

  function automatic logic [127:0] rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] l0, l1;

  initial begin
    arst_i = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_pc_i = '0;
    fetch_line_i = '0;
    fetch_taken_i = 1'b0;
    fetch_taken_slot_i = 2'd0;
    fo_if.ready = 1'b0;
    fl_if.flush = 1'b0;

    // Reset values
    #12;
    check("rst_count", 128'(count_o), 128'(0));
    check("rst_valid", 128'(fo_if.valid), 128'(0));
    check("rst_validword", 128'(fo_if.validword), 128'(0));
    check("rst_ready", 128'(fetch_ready_o), 128'(1));
    @(posedge clk_i); #2;
    arst_i = 1'b0;
    step();

    // Group build: start=2, end=3
    drive(32'h0000_1008, rline(), 1'b0, 2'd0);
    @(negedge clk_i);
    check("g1_valid", 128'(fo_if.valid), 128'(1));
    check("g1_grouppc", 128'(fo_if.grouppc), 128'(32'h1000));
    check("g1_validword", 128'(fo_if.validword), 128'(4'b1100));
    check("g1_count", 128'(count_o), 128'(1));
    fo_if.ready = 1'b1; step(); fo_if.ready = 1'b0;

    // Taken slot inside range, then taken slot before start (clamped)
    drive(32'h0000_2004, rline(), 1'b1, 2'd2);
    drive(32'h0000_200C, rline(), 1'b1, 2'd1);
    @(negedge clk_i);
    check("g2_validword", 128'(fo_if.validword), 128'(4'b0110));
    fo_if.ready = 1'b1; step();
    @(negedge clk_i);
    check("g3_validword", 128'(fo_if.validword), 128'(4'b1000));
    check("g3_grouppc", 128'(fo_if.grouppc), 128'(32'h2000));
    step(); fo_if.ready = 1'b0;

    // Fill to DEPTH, overflow push refused, then drain in order
    for (int i = 0; i < DEPTH; i++) drive(32'h3000 + 32'(i * 20), rline(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    @(negedge clk_i);
    check("full_ready", 128'(fetch_ready_o), 128'(0));
    check("full_count", 128'(count_o), 128'(DEPTH));
    drive(32'h0000_4000, rline(), 1'b0, 2'd0);
    @(negedge clk_i);
    check("overflow_count", 128'(count_o), 128'(DEPTH));
    fo_if.ready = 1'b1;
    repeat (DEPTH) step();
    fo_if.ready = 1'b0;
    @(negedge clk_i);
    check("drained_valid", 128'(fo_if.valid), 128'(0));

    // Head held stable while decode stalls
    l0 = rline(); l1 = rline();
    drive(32'h0000_5014, l0, 1'b1, 2'd3);
    drive(32'h0000_6000, l1, 1'b0, 2'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("hold_instr", fo_if.instr, l0);
      check("hold_grouppc", 128'(fo_if.grouppc), 128'(32'h5010));
      check("hold_validword", 128'(fo_if.validword), 128'(4'b1110));
      step();
    end
    // Concurrent push/pop at count 2
    fetch_valid_i = 1'b1; fetch_pc_i = 32'h0000_7008; fetch_line_i = rline();
    fetch_taken_i = 1'b0; fo_if.ready = 1'b1;
    step();
    fetch_valid_i = 1'b0; fo_if.ready = 1'b0;
    @(negedge clk_i);
    check("pushpop_count", 128'(count_o), 128'(2));
    check("pushpop_head", fo_if.instr, l1);

    // Flush with push and pop active
    drive(32'h0000_8000, rline(), 1'b0, 2'd0);
    fetch_valid_i = 1'b1; fetch_pc_i = 32'h0000_9000; fo_if.ready = 1'b1; fl_if.flush = 1'b1;
    step();
    fetch_valid_i = 1'b0; fo_if.ready = 1'b0; fl_if.flush = 1'b0;
    @(negedge clk_i);
    check("flush_count", 128'(count_o), 128'(0));
    check("flush_valid", 128'(fo_if.valid), 128'(0));
    check("flush_validword", 128'(fo_if.validword), 128'(0));
    check("flush_ready", 128'(fetch_ready_o), 128'(1));

    // Random stream of 10 groups across pointer wrap
    begin
      int sent = 0;
      int budget = 200;
      pops = 0;
      while (sent < 10 && budget > 0) begin
        fetch_valid_i = 1'b1;
        fetch_pc_i = {$urandom_range(0, 32'hFFFF), 2'b00};
        fetch_line_i = rline();
        fetch_taken_i = 1'($urandom_range(0, 1));
        fetch_taken_slot_i = 2'($urandom_range(0, 3));
        fo_if.ready = 1'($urandom_range(0, 1));
        if (fetch_ready_o) sent++;
        step();
        budget--;
      end
      fetch_valid_i = 1'b0;
      fo_if.ready = 1'b1;
      budget = 50;
      while (fo_if.valid && budget > 0) begin step(); budget--; end
      fo_if.ready = 1'b0;
      check("stream_sent", 128'(sent), 128'(10));
      check("stream_popped", 128'(pops), 128'(10));
      @(negedge clk_i);
      check("stream_empty", 128'(fo_if.valid), 128'(0));
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drive(32'hA000 + 32'(i * 16), rline(), 1'b0, 2'd0);
    #2;
    arst_i = 1'b1;
    sb_q.delete();
    #1;
    check("arst_count", 128'(count_o), 128'(0));
    check("arst_valid", 128'(fo_if.valid), 128'(0));
    check("arst_validword", 128'(fo_if.validword), 128'(0));
    @(posedge clk_i); #2;
    arst_i = 1'b0;
    @(negedge clk_i);
    check("post_arst_valid", 128'(fo_if.valid), 128'(0));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
